// File: rtl/reg_write_queue_pkg.sv
// ============================================================================
// Module   : reg_write_queue_pkg
// Purpose  : Shared types and constants for the register write queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_write_queue_pkg;

  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [4:0]  REG_ZERO      = 5'd0;

  typedef struct packed {
    logic [4:0]  regNum;
    logic [31:0] data;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/reg_write_queue_match.sv
// ============================================================================
// Module   : reg_queue_match
// Purpose  : Hazard lookup of one read register against the queued writes;
//            with REG_WRITE_BYPASS_EN it also returns the newest matching data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_queue_match
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
)
(
  input  logic [DEPTH-1:0][4:0]      regNums,
`ifdef REG_WRITE_BYPASS_EN
  input  logic [DEPTH-1:0][31:0]     datas,
  output logic [31:0]                newestData,
`endif
  input  logic [$clog2(DEPTH)-1:0]   rdPtr,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [4:0]                 queryReg,
  output logic                       pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] w_idx;

  // Walk from head to tail so the last hit is the newest queued write.
  always_comb begin
    pending = 1'b0;
    w_idx   = '0;
`ifdef REG_WRITE_BYPASS_EN
    newestData = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = rdPtr + PW'(k);
      if ((CW'(k) < count) && (queryReg != REG_ZERO) &&
          (regNums[w_idx] == queryReg)) begin
        pending = 1'b1;
`ifdef REG_WRITE_BYPASS_EN
        newestData = datas[w_idx];
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_queue.sv
// ============================================================================
// Module   : reg_write_queue
// Purpose  : Two-source register-file write queue with one drain per cycle
//            and hazard lookup. Optional macro REG_WRITE_BYPASS_EN adds
//            newest-match data bypass ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_queue
  import reg_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
)
(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       AluValid,
  output logic                       AluReady,
  input  logic [4:0]                 AluReg,
  input  logic [31:0]                AluData,
  input  logic                       MemValid,
  output logic                       MemReady,
  input  logic [4:0]                 MemReg,
  input  logic [31:0]                MemData,
  output logic [4:0]                 WriteRegister,
  output logic [31:0]                WriteData,
  output logic                       RegWrite,
  input  logic [4:0]                 ReadRegister1,
  input  logic [4:0]                 ReadRegister2,
  output logic                       Pending1,
  output logic                       Pending2,
`ifdef REG_WRITE_BYPASS_EN
  output logic [31:0]                BypassData1,
  output logic [31:0]                BypassData2,
`endif
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_wrPtr;
  entry_t [DEPTH-1:0]    r_entries;

  logic                  w_pop;
  logic                  w_memPush;
  logic                  w_aluPush;
  logic [CW-1:0]         w_freeSlots;
  logic [PW-1:0]         w_aluIdx;
  entry_t                w_head;
  logic [DEPTH-1:0][4:0] w_regNums;
  logic                  w_pend1;
  logic                  w_pend2;

  // The head drains unconditionally whenever anything is queued.
  assign w_pop    = !Reset && (r_count != '0);
  assign MemReady = !Reset && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_memPush = MemValid && MemReady && (MemReg != REG_ZERO);

  // Slots left once this cycle's pop and any Mem enqueue are accounted for.
  assign w_freeSlots = CW'(DEPTH) - r_count + CW'(w_pop) - CW'(w_memPush);
  assign AluReady    = !Reset && (w_freeSlots != '0);
  assign w_aluPush   = AluValid && AluReady && (AluReg != REG_ZERO);

  // Mem goes first, so Alu lands one slot behind it when both push.
  assign w_aluIdx = r_wrPtr + PW'(w_memPush);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
    end else begin
      r_count <= r_count + CW'(w_memPush) + CW'(w_aluPush) - CW'(w_pop);
      r_rdPtr <= r_rdPtr + PW'(w_pop);
      r_wrPtr <= r_wrPtr + PW'(w_memPush) + PW'(w_aluPush);
    end
  end

  always_ff @(posedge Clk) begin
    if (w_memPush) begin
      r_entries[r_wrPtr] <= '{regNum: MemReg, data: MemData};
    end
    if (w_aluPush) begin
      r_entries[w_aluIdx] <= '{regNum: AluReg, data: AluData};
    end
  end

  assign w_head        = r_entries[r_rdPtr];
  assign RegWrite      = w_pop;
  assign WriteRegister = w_pop ? w_head.regNum : '0;
  assign WriteData     = w_pop ? w_head.data   : '0;
  assign Count         = r_count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_regNums
    assign w_regNums[i] = r_entries[i].regNum;
  end

`ifdef REG_WRITE_BYPASS_EN
  logic [DEPTH-1:0][31:0] w_datas;

  for (genvar i = 0; i < DEPTH; i++) begin : g_datas
    assign w_datas[i] = r_entries[i].data;
  end
`endif

  reg_queue_match #(.DEPTH(DEPTH)) u_match1 (
    .regNums    (w_regNums),
`ifdef REG_WRITE_BYPASS_EN
    .datas      (w_datas),
    .newestData (BypassData1),
`endif
    .rdPtr      (r_rdPtr),
    .count      (r_count),
    .queryReg   (ReadRegister1),
    .pending    (w_pend1)
  );

  reg_queue_match #(.DEPTH(DEPTH)) u_match2 (
    .regNums    (w_regNums),
`ifdef REG_WRITE_BYPASS_EN
    .datas      (w_datas),
    .newestData (BypassData2),
`endif
    .rdPtr      (r_rdPtr),
    .count      (r_count),
    .queryReg   (ReadRegister2),
    .pending    (w_pend2)
  );

  assign Pending1 = !Reset && w_pend1;
  assign Pending2 = !Reset && w_pend2;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_queue.sv
// ============================================================================
// Module   : tb_reg_write_queue
// Purpose  : Self-checking bench for reg_write_queue (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_queue;
  import reg_write_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          AluValid, MemValid;
  logic          AluReady, MemReady;
  logic [4:0]    AluReg, MemReg;
  logic [31:0]   AluData, MemData;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic          RegWrite;
  logic [4:0]    ReadRegister1, ReadRegister2;
  logic          Pending1, Pending2;
  logic [CW-1:0] Count;
`ifdef REG_WRITE_BYPASS_EN
  logic [31:0]   BypassData1, BypassData2;
`endif

  int checks = 0;
  int errors = 0;
  entry_t sb[$];

  always #5 Clk = ~Clk;

  reg_write_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Pending1(Pending1), .Pending2(Pending2),
`ifdef REG_WRITE_BYPASS_EN
    .BypassData1(BypassData1), .BypassData2(BypassData2),
`endif
    .Count(Count)
  );

  // Scoreboard monitor: compares outputs against the queue model, then
  // advances the model across one clock edge.
  task automatic tick();
    int sz, freeSlots;
    bit pop, mRdy, aRdy, mPush, aPush, p1, p2;
    logic [31:0] b1, b2;
    logic [CW-1:0] expCount;
    #1;
    sz    = sb.size();
    pop   = !Reset && (sz != 0);
    mRdy  = !Reset && ((sz < DEPTH) || pop);
    mPush = MemValid && mRdy && (MemReg != 5'd0);
    freeSlots = DEPTH - sz + int'(pop) - int'(mPush);
    aRdy  = !Reset && (freeSlots > 0);
    aPush = AluValid && aRdy && (AluReg != 5'd0);
    p1 = 1'b0; p2 = 1'b0; b1 = '0; b2 = '0;
    foreach (sb[j]) begin
      if (ReadRegister1 != 5'd0 && sb[j].regNum == ReadRegister1) begin p1 = 1'b1; b1 = sb[j].data; end
      if (ReadRegister2 != 5'd0 && sb[j].regNum == ReadRegister2) begin p2 = 1'b1; b2 = sb[j].data; end
    end
    if (Reset) begin p1 = 1'b0; p2 = 1'b0; end
    expCount = CW'(sz);

    checks++; if (RegWrite !== pop) begin errors++; $display("FAIL regwrite: got %b expected %b", RegWrite, pop); end
    checks++; if (MemReady !== mRdy) begin errors++; $display("FAIL memready: got %b expected %b", MemReady, mRdy); end
    checks++; if (AluReady !== aRdy) begin errors++; $display("FAIL aluready: got %b expected %b", AluReady, aRdy); end
    checks++; if (Pending1 !== p1) begin errors++; $display("FAIL pending1: got %b expected %b", Pending1, p1); end
    checks++; if (Pending2 !== p2) begin errors++; $display("FAIL pending2: got %b expected %b", Pending2, p2); end
    if (!Reset) begin
      checks++; if (Count !== expCount) begin errors++; $display("FAIL count: got %0d expected %0d", Count, expCount); end
      if (pop) begin
        checks++; if (WriteRegister !== sb[0].regNum) begin errors++; $display("FAIL wreg: got %0d expected %0d", WriteRegister, sb[0].regNum); end
        checks++; if (WriteData !== sb[0].data) begin errors++; $display("FAIL wdata: got %h expected %h", WriteData, sb[0].data); end
      end else begin
        checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL wreg_empty: got %0d expected 0", WriteRegister); end
        checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL wdata_empty: got %h expected 0", WriteData); end
      end
`ifdef REG_WRITE_BYPASS_EN
      checks++; if (BypassData1 !== b1) begin errors++; $display("FAIL bypass1: got %h expected %h", BypassData1, b1); end
      checks++; if (BypassData2 !== b2) begin errors++; $display("FAIL bypass2: got %h expected %h", BypassData2, b2); end
`endif
    end
    @(posedge Clk);
    if (Reset) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (mPush) sb.push_back('{regNum: MemReg, data: MemData});
      if (aPush) sb.push_back('{regNum: AluReg, data: AluData});
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    AluValid = 1'b0; MemValid = 1'b0;
    AluReg = '0; MemReg = '0; AluData = '0; MemData = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle();
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++; if (Count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    tick();
  endtask

  task automatic test_single();
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h12345678;
    tick();
    idle();
    #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_regwrite: got %b expected 1", RegWrite); end
    checks++; if (WriteRegister !== 5'd5) begin errors++; $display("FAIL single_wreg: got %0d expected 5", WriteRegister); end
    checks++; if (WriteData !== 32'h12345678) begin errors++; $display("FAIL single_wdata: got %h expected 12345678", WriteData); end
    tick();
    checks++; if (Count !== '0) begin errors++; $display("FAIL single_drain: got %0d expected 0", Count); end
  endtask

  task automatic test_dual();
    MemValid = 1'b1; MemReg = 5'd3; MemData = 32'hAA;
    AluValid = 1'b1; AluReg = 5'd4; AluData = 32'hBB;
    tick();
    idle();
    #1;
    checks++; if (Count !== CW'(2)) begin errors++; $display("FAIL dual_peak: got %0d expected 2", Count); end
    checks++; if (WriteRegister !== 5'd3) begin errors++; $display("FAIL dual_first: got %0d expected 3", WriteRegister); end
    tick();
    checks++; if (WriteRegister !== 5'd4) begin errors++; $display("FAIL dual_second: got %0d expected 4", WriteRegister); end
    tick(); tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 6; i++) begin
      MemValid = 1'b1; MemReg = 5'(10 + 2*i); MemData = 32'h100 + i;
      AluValid = 1'b1; AluReg = 5'(11 + 2*i); AluData = 32'h200 + i;
      #1;
      if (i >= 3) begin
        checks++; if (Count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", Count, DEPTH); end
        checks++; if (AluReady !== 1'b0) begin errors++; $display("FAIL full_aluready: got %b expected 0", AluReady); end
        checks++; if (MemReady !== 1'b1) begin errors++; $display("FAIL full_memready: got %b expected 1", MemReady); end
      end
      tick();
    end
    idle();
    #1;
    checks++; if (Count !== CW'(DEPTH)) begin errors++; $display("FAIL full_hold: got %0d expected %0d", Count, DEPTH); end
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic test_zero();
    AluValid = 1'b1; AluReg = 5'd0; AluData = 32'hFFFFFFFF;
    ReadRegister1 = 5'd0;
    #1;
    checks++; if (AluReady !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", AluReady); end
    checks++; if (Pending1 !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b expected 0", Pending1); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL zero_regwrite: got %b expected 0", RegWrite); end
      tick();
    end
  endtask

  task automatic test_pending();
    MemValid = 1'b1; MemReg = 5'd7; MemData = 32'h1;
    AluValid = 1'b1; AluReg = 5'd7; AluData = 32'h2;
    tick();
    idle();
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
    #1;
    checks++; if (Pending1 !== 1'b1) begin errors++; $display("FAIL pend_hit: got %b expected 1", Pending1); end
    checks++; if (Pending2 !== 1'b0) begin errors++; $display("FAIL pend_miss: got %b expected 0", Pending2); end
`ifdef REG_WRITE_BYPASS_EN
    checks++; if (BypassData1 !== 32'h2) begin errors++; $display("FAIL pend_bypass: got %h expected 2", BypassData1); end
`endif
    tick(); tick(); tick();
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
  endtask

  task automatic test_reset_mid();
    MemValid = 1'b1; MemReg = 5'd20; MemData = 32'hC0;
    AluValid = 1'b1; AluReg = 5'd21; AluData = 32'hC1;
    tick();
    MemReg = 5'd22; MemData = 32'hC2; AluReg = 5'd23; AluData = 32'hC3;
    tick();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL midreset_regwrite: got %b expected 0", RegWrite); end
      checks++; if (Count !== '0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", Count); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      MemValid = 1'($urandom_range(0, 1));
      AluValid = 1'($urandom_range(0, 1));
      MemReg   = 5'($urandom_range(0, 7));
      AluReg   = 5'($urandom_range(0, 7));
      MemData  = $urandom;
      AluData  = $urandom;
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  initial begin
    Reset = 1'b1; idle();
    ReadRegister1 = '0; ReadRegister2 = '0;
    @(negedge Clk);
    test_reset();
    test_single();
    test_dual();
    test_full();
    test_zero();
    test_pending();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
